// File: rtl/packet_stream_arbiter.sv
// packet_stream_arbiter: packet-granular round-robin merge of NUM_PORTS sources onto the parser bus.
// Optional feature macro PKT_ARB_STATS_EN adds per-port accepted-packet counters on pkt_count.
module packet_stream_arbiter #(
    parameter int NUM_PORTS        = 4,
    parameter int WIDTH_DATA_BYTES = 8,
    parameter int MIN_GAP          = 1
) (
    input  logic                                  clk_host,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  src_valid,
    input  logic [NUM_PORTS-1:0]                  src_sop,
    input  logic [NUM_PORTS-1:0]                  src_eop,
    input  logic [NUM_PORTS*WIDTH_DATA_BYTES-1:0] src_byteen,
    input  logic [NUM_PORTS*8*WIDTH_DATA_BYTES-1:0] src_data,
    output logic [NUM_PORTS-1:0]                  src_ready,
    output logic                                  bus_out_valid,
    output logic                                  bus_out_sop,
    output logic                                  bus_out_eop,
    output logic [WIDTH_DATA_BYTES-1:0]           bus_out_byteen,
    output logic [8*WIDTH_DATA_BYTES-1:0]         bus_out_data,
    output logic [$clog2(NUM_PORTS)-1:0]          grant_port,
    output logic                                  err_gap
`ifdef PKT_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]               pkt_count
`endif
);

    localparam int WDB = WIDTH_DATA_BYTES;
    localparam int DW  = 8 * WDB;
    localparam int PW  = $clog2(NUM_PORTS);
    localparam logic [3:0] GAP_LAST = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t         state, state_d;
    logic [PW-1:0]  rr_ptr, rr_d, grant_d, pick;
    logic [3:0]     gap_cnt, gap_d;
    logic           pick_vld;
    logic [NUM_PORTS-1:0] req;
    logic           g_valid, g_sop, g_eop;
    logic [WDB-1:0] g_be;
    logic [DW-1:0]  g_data;
    logic           accept, accept_eop;

    assign req        = src_valid & src_sop;
    assign g_valid    = src_valid[grant_port];
    assign g_sop      = src_sop[grant_port];
    assign g_eop      = src_eop[grant_port];
    assign g_be       = src_byteen[grant_port*WDB +: WDB];
    assign g_data     = src_data[grant_port*DW +: DW];
    assign accept     = (state == XFER) && g_valid;
    assign accept_eop = accept && g_eop;

    // First sop requester at or after rr_ptr, wrapping around the ports
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_PORTS;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick     = PW'(idx);
            end
        end
    end

    // Next-state, grant/pointer update and per-port ready
    always_comb begin
        state_d   = state;
        rr_d      = rr_ptr;
        grant_d   = grant_port;
        gap_d     = gap_cnt;
        src_ready = '0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    rr_d    = PW'((int'(pick) + 1) % NUM_PORTS);
                    state_d = XFER;
                end
            end
            XFER: begin
                src_ready[grant_port] = 1'b1;
                if (accept_eop) begin
                    gap_d   = 4'd0;
                    state_d = (MIN_GAP > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_d = IDLE;
                else                     gap_d   = gap_cnt + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_host) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Arbitration context and gap counter
    always_ff @(posedge clk_host) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            grant_port <= '0;
            gap_cnt    <= '0;
        end else begin
            rr_ptr     <= rr_d;
            grant_port <= grant_d;
            gap_cnt    <= gap_d;
        end
    end

    // Registered output beat; payload zeroed whenever the bus is idle
    always_ff @(posedge clk_host) begin
        if (!rst_n) begin
            bus_out_valid  <= 1'b0;
            bus_out_sop    <= 1'b0;
            bus_out_eop    <= 1'b0;
            bus_out_byteen <= '0;
            bus_out_data   <= '0;
            err_gap        <= 1'b0;
        end else begin
            bus_out_valid  <= accept;
            bus_out_sop    <= accept && g_sop;
            bus_out_eop    <= accept && g_eop;
            bus_out_byteen <= accept ? g_be : '0;
            bus_out_data   <= accept ? g_data : '0;
            err_gap        <= (state == XFER) && !g_valid;
        end
    end

`ifdef PKT_ARB_STATS_EN
    // Per-port count of packets whose eop beat was accepted, wrapping at 16 bits
    always_ff @(posedge clk_host) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (accept_eop) begin
            pkt_count[grant_port*16 +: 16] <= pkt_count[grant_port*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule
